// File: rtl/jk_counter_mod.sv
// Parametrised modulo counter built from JK stages with up/down, enable, parallel load,
// combinational terminal count and a registered one-cycle wrap pulse.
module jk_counter_mod #(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH:0]   MOD_EXT    = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH-1:0] Q_MAX      = WIDTH'(MODULUS - 1);
   localparam bit               FULL_RANGE = (MODULUS == (1 << WIDTH));

   generate
      if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
         $error("jk_counter_mod: illegal WIDTH/MODULUS combination");
      end
   endgenerate

   logic             at_max;
   logic             at_zero;
   logic             in_range;
   logic [WIDTH-1:0] load_d;
   logic [WIDTH-1:0] t_up;
   logic [WIDTH-1:0] t_dn;
   logic [WIDTH-1:0] toggle;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;

   assign at_max   = (Q == Q_MAX);
   assign at_zero  = (Q == '0);
   assign in_range = ({1'b0, Q} < MOD_EXT);
   assign load_d   = ({1'b0, load_val} >= MOD_EXT) ? Q_MAX : load_val;

   // Ripple-carry toggle terms: bit i flips when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      t_up    = '0;
      t_dn    = '0;
      t_up[0] = 1'b1;
      t_dn[0] = 1'b1;
      for (int unsigned i = 1; i < WIDTH; i++) begin
         t_up[i] = t_up[i-1] & Q[i-1];
         t_dn[i] = t_dn[i-1] & ~Q[i-1];
      end
   end

   // Truncated moduli need wrap correction: toggling the set bits of Q reaches 0,
   // toggling the bits of Q_MAX from 0 reaches Q_MAX.
   always_comb begin
      toggle = up_dn ? t_up : t_dn;
      if (!FULL_RANGE) begin
         if (!in_range) begin
            toggle = Q;
         end else if (up_dn && at_max) begin
            toggle = Q;
         end else if (!up_dn && at_zero) begin
            toggle = Q_MAX;
         end
      end
   end

   always_comb begin
      if (load) begin
         j = load_d;
         k = ~load_d;
      end else if (en) begin
         j = toggle;
         k = toggle;
      end else begin
         j = '0;
         k = '0;
      end
   end

   assign tc = en & ~load & ((up_dn & at_max) | (~up_dn & at_zero));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Q    <= '0;
         wrap <= 1'b0;
      end else begin
         Q    <= (j & ~Q) | (~k & Q);
         wrap <= tc;
      end
   end

endmodule

// File: tb/tb_jk_counter_mod.sv
// Bench for jk_counter_mod: a 3/8 and a 3/6 instance share stimulus; an arithmetic model
// is compared every cycle, with directed literal expectations pinning the model.
module tb_jk_counter_mod;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       up_dn;
   logic       load;
   logic [2:0] load_val;
   logic [2:0] q8;
   logic [2:0] q6;
   logic       tc8;
   logic       tc6;
   logic       wrap8;
   logic       wrap6;

   int errors = 0;
   int checks = 0;

   int mq8 = 0;
   int mq6 = 0;
   bit mw8 = 1'b0;
   bit mw6 = 1'b0;

   always #5 clk = ~clk;

   jk_counter_mod dut8 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .Q(q8), .tc(tc8), .wrap(wrap8)
   );

   jk_counter_mod #(.WIDTH(3), .MODULUS(6)) dut6 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .Q(q6), .tc(tc6), .wrap(wrap6)
   );

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
      end
   endtask

   function automatic bit model_tc(input int q, input int m);
      return en && !load && ((up_dn && q == m - 1) || (!up_dn && q == 0));
   endfunction

   function automatic int model_next(input int q, input int m);
      if (load) return (int'(load_val) >= m) ? m - 1 : int'(load_val);
      if (!en) return q;
      if (up_dn) return (q == m - 1) ? 0 : q + 1;
      return (q == 0) ? m - 1 : q - 1;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq8 <= 0;
         mq6 <= 0;
         mw8 <= 1'b0;
         mw6 <= 1'b0;
      end else begin
         mq8 <= model_next(mq8, 8);
         mq6 <= model_next(mq6, 6);
         mw8 <= model_tc(mq8, 8);
         mw6 <= model_tc(mq6, 6);
      end
   end

   always @(negedge clk) begin
      check("model_q8",    int'(q8),    mq8);
      check("model_tc8",   int'(tc8),   int'(model_tc(mq8, 8)));
      check("model_wrap8", int'(wrap8), int'(mw8));
      check("model_q6",    int'(q6),    mq6);
      check("model_tc6",   int'(tc6),   int'(model_tc(mq6, 6)));
      check("model_wrap6", int'(wrap6), int'(mw6));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit l, input bit e, input bit u, input logic [2:0] v);
      load     = l;
      en       = e;
      up_dn    = u;
      load_val = v;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 1'b1, 1'b1, 3'd0);
      #2;
      check("rst_q8", int'(q8), 0);
      check("rst_wrap8", int'(wrap8), 0);
      check("rst_tc8", int'(tc8), 0);
      #8 reset = 1'b1;

      // Count up through a full period of both moduli.
      for (int n = 1; n <= 8; n++) begin
         tick();
         check("up_q8", int'(q8), n % 8);
         check("up_q6", int'(q6), n % 6);
         if (n == 7) check("up_tc8_at7", int'(tc8), 1);
         if (n == 6) check("up_wrap6", int'(wrap6), 1);
         if (n == 8) check("up_wrap8", int'(wrap8), 1);
      end

      // Mod-6 down from 0 wraps to 5.
      drive(1'b1, 1'b1, 1'b1, 3'd0);
      tick();
      check("load0_q6", int'(q6), 0);
      drive(1'b0, 1'b1, 1'b0, 3'd0);
      #1 check("dn_tc6_at0", int'(tc6), 1);
      tick();
      check("dn_wrap_q6", int'(q6), 5);
      check("dn_wrap6", int'(wrap6), 1);
      check("dn_wrap_q8", int'(q8), 7);
      repeat (5) tick();
      check("dn_q6_end", int'(q6), 0);
      check("dn_tc6_end", int'(tc6), 1);
      tick();
      check("dn_q6_rewrap", int'(q6), 5);
      drive(1'b0, 1'b1, 1'b1, 3'd0);
      #1 check("up_tc6_at5", int'(tc6), 1);
      tick();
      check("up_q6_wrap", int'(q6), 0);
      check("up_wrap6_b", int'(wrap6), 1);

      // Load has priority over count and clamps out-of-range values.
      drive(1'b1, 1'b1, 1'b1, 3'd3);
      #1 check("load_tc_block", int'(tc6), 0);
      tick();
      check("load3_q6", int'(q6), 3);
      check("load3_q8", int'(q8), 3);
      drive(1'b1, 1'b1, 1'b1, 3'd7);
      tick();
      check("load7_q6", int'(q6), 5);
      check("load7_q8", int'(q8), 7);
      check("load7_wrap8", int'(wrap8), 0);

      // Hold with enable low.
      drive(1'b1, 1'b1, 1'b1, 3'd4);
      tick();
      drive(1'b0, 1'b0, 1'b1, 3'd0);
      repeat (4) begin
         tick();
         check("hold_q8", int'(q8), 4);
         check("hold_q6", int'(q6), 4);
         check("hold_tc8", int'(tc8), 0);
         check("hold_wrap8", int'(wrap8), 0);
      end
      drive(1'b0, 1'b1, 1'b1, 3'd0);
      tick();
      check("resume_q8", int'(q8), 5);
      check("resume_q6", int'(q6), 5);

      // Asynchronous reset between edges.
      drive(1'b1, 1'b1, 1'b1, 3'd6);
      tick();
      check("pre_rst_q8", int'(q8), 6);
      drive(1'b0, 1'b1, 1'b1, 3'd0);
      #2 reset = 1'b0;
      #1;
      check("async_q8", int'(q8), 0);
      check("async_wrap8", int'(wrap8), 0);
      check("async_q6", int'(q6), 0);
      repeat (2) begin
         tick();
         check("rst_hold_q8", int'(q8), 0);
      end
      reset = 1'b1;
      tick();
      check("post_rst_q8", int'(q8), 1);
      check("post_rst_q6", int'(q6), 1);

      // Direction flip at the top of the range: no wrap.
      drive(1'b1, 1'b1, 1'b1, 3'd7);
      tick();
      check("flip_pre_q8", int'(q8), 7);
      drive(1'b0, 1'b1, 1'b0, 3'd0);
      #1 check("flip_tc8", int'(tc8), 0);
      tick();
      check("flip_q8", int'(q8), 6);
      check("flip_wrap8", int'(wrap8), 0);
      check("flip_q6", int'(q6), 4);

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
